// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and types for the VGA framebuffer arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
package vga_pkg;

  localparam int H_ACT_START = 140;
  localparam int V_ACT_START = 34;
  localparam int H_ACT       = 640;
  localparam int V_ACT       = 480;
  localparam int FB_W        = 320;
  localparam int FB_H        = 240;
  localparam int FB_SIZE     = 76800;
  localparam int ADDR_W      = 17;
  localparam int DATA_W      = 8;

  typedef logic [16:0] fb_addr_t;
  typedef logic [7:0]  pixel_t;

  typedef enum logic [1:0] {
    S_BLANK  = 2'd0,
    S_ACT_RD = 2'd1,
    S_ACT_WR = 2'd2
  } arb_state_t;

  // Row base r*320 built as (r<<8)+(r<<6) so no multiplier is inferred.
  function automatic fb_addr_t row_base(input logic [7:0] r);
    fb_addr_t w_r;
    w_r = {9'd0, r};
    return (w_r << 8) + (w_r << 6);
  endfunction

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Classifies each pixel-clock cycle as read slot / write-window slot and forms the read address.
// Latency: purely combinational on the counters.
// Backpressure: none; the display path is never stalled.
//
// Ports:
//   i_h_cont, i_v_cont : counters from the VGA timing controller
//   o_rd_slot          : display read must be issued this cycle
//   o_wr_win           : odd slot inside the active read window
//   o_rd_addr          : linear framebuffer address for the read slot
module vga_fb_addr_gen
  import vga_pkg::*;
#(
  parameter int P_H_ACT_START = H_ACT_START,
  parameter int P_V_ACT_START = V_ACT_START,
  parameter int P_V_ACT       = V_ACT,
  parameter int P_FB_W        = FB_W
) (
  input  logic [9:0]  i_h_cont,
  input  logic [9:0]  i_v_cont,
  output logic        o_rd_slot,
  output logic        o_wr_win,
  output logic [16:0] o_rd_addr
);

  // Reads start three cycles ahead of the first visible pixel to cover
  // address register + RAM latency + pixel capture.
  localparam logic [9:0] RD_H0 = 10'(P_H_ACT_START - 3);
  localparam logic [9:0] RD_H1 = 10'(P_H_ACT_START - 3 + 2 * P_FB_W - 2);
  localparam logic [9:0] LN_V0 = 10'(P_V_ACT_START);
  localparam logic [9:0] LN_V1 = 10'(P_V_ACT_START + P_V_ACT);

  logic       w_line_act;
  logic       w_in_win;
  logic [9:0] w_s;
  logic [9:0] w_y;
  logic [7:0] w_row;
  logic [8:0] w_col;

  assign w_line_act = (i_v_cont >= LN_V0) && (i_v_cont < LN_V1);
  assign w_in_win   = (i_h_cont >= RD_H0) && (i_h_cont <= RD_H1);
  assign w_s        = i_h_cont - RD_H0;
  assign w_y        = i_v_cont - LN_V0;

  // Vertical doubling: display lines 2r and 2r+1 both fetch buffer row r.
  assign w_row = 8'(w_y >> 1);
  assign w_col = 9'(w_s >> 1);

  assign o_rd_slot = w_line_act && w_in_win && !w_s[0];
  assign o_wr_win  = w_line_act && w_in_win &&  w_s[0];
  assign o_rd_addr = row_base(w_row) + {8'd0, w_col};

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port 320x240x8 framebuffer between 2x-scaled VGA scan-out and a host write port.
// Latency: read address 1 cycle after slot, pixel out 3 cycles after slot; host ack 1 cycle after accept.
// Backpressure: display reads always win; host request waits (max 1 cycle active, 0 in blanking) via oWr_Ack.
//
// Ports:
//   iCLK, iRST_N                  : pixel clock, synchronous active-low reset
//   iH_Cont, iV_Cont              : timing controller counters
//   iWr_Req/Addr/Data, oWr_Ack    : host write port (level request, one-cycle ack)
//   oMem_Addr/WE/WData, iMem_RData: single-port RAM interface (1-cycle read latency)
//   oPixel, oPixel_Valid          : pixel for the current counter position
//   iStats_Clr, oWait_Max         : only with VGA_FB_ARB_WAIT_STATS_EN defined
//
// Optional: define VGA_FB_ARB_WAIT_STATS_EN to add a saturating max request-to-ack wait counter.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int P_H_ACT_START = H_ACT_START,
  parameter int P_V_ACT_START = V_ACT_START,
  parameter int P_H_ACT       = H_ACT,
  parameter int P_V_ACT       = V_ACT,
  parameter int P_FB_W        = FB_W,
  parameter int P_FB_H        = FB_H,
  parameter int P_ADDR_W      = ADDR_W,
  parameter int P_DATA_W      = DATA_W
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic [9:0]          iH_Cont,
  input  logic [9:0]          iV_Cont,
  input  logic                iWr_Req,
  input  logic [P_ADDR_W-1:0] iWr_Addr,
  input  logic [P_DATA_W-1:0] iWr_Data,
  output logic                oWr_Ack,
  output logic [P_ADDR_W-1:0] oMem_Addr,
  output logic                oMem_WE,
  output logic [P_DATA_W-1:0] oMem_WData,
  input  logic [P_DATA_W-1:0] iMem_RData,
`ifdef VGA_FB_ARB_WAIT_STATS_EN
  input  logic                iStats_Clr,
  output logic [15:0]         oWait_Max,
`endif
  output logic [P_DATA_W-1:0] oPixel,
  output logic                oPixel_Valid
);

  localparam logic [P_ADDR_W-1:0] FB_LIMIT = P_ADDR_W'(P_FB_W * P_FB_H);

  logic                w_rd_slot;
  logic                w_wr_win;
  logic [16:0]         w_rd_addr;
  arb_state_t          w_slot;
  logic                w_wr_pend;
  logic                w_wr_accept;

  // r_state holds the previous cycle's slot class, so r_state == S_ACT_RD
  // marks the cycle in which the read address is on the RAM bus.
  arb_state_t          r_state;
  logic [P_ADDR_W-1:0] r_addr;
  logic                r_we;
  logic [P_DATA_W-1:0] r_wdata;
  logic                r_ack;
  logic                r_rd_p2;
  logic                r_rd_p3;
  logic [P_DATA_W-1:0] r_pix;
  logic                r_pix_vld;

  vga_fb_addr_gen #(
    .P_H_ACT_START (P_H_ACT_START),
    .P_V_ACT_START (P_V_ACT_START),
    .P_V_ACT       (P_V_ACT),
    .P_FB_W        (P_FB_W)
  ) u_addr_gen (
    .i_h_cont  (iH_Cont),
    .i_v_cont  (iV_Cont),
    .o_rd_slot (w_rd_slot),
    .o_wr_win  (w_wr_win),
    .o_rd_addr (w_rd_addr)
  );

  always_comb begin
    w_slot = S_BLANK;
    if (w_rd_slot) begin
      w_slot = S_ACT_RD;
    end else if (w_wr_win) begin
      w_slot = S_ACT_WR;
    end
  end

  // While oWr_Ack is high the host still shows the request it just had
  // accepted, so it must not be taken a second time.
  assign w_wr_pend   = iWr_Req && !r_ack;
  assign w_wr_accept = w_wr_pend && (w_slot != S_ACT_RD);

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state   <= S_BLANK;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_ack     <= 1'b0;
      r_rd_p2   <= 1'b0;
      r_rd_p3   <= 1'b0;
      r_pix     <= '0;
      r_pix_vld <= 1'b0;
    end else begin
      r_state <= w_slot;
      r_we    <= 1'b0;
      r_ack   <= 1'b0;

      // S_BLANK and S_ACT_WR behave identically: both are write slots.
      case (w_slot)
        S_ACT_RD: begin
          r_addr <= P_ADDR_W'(w_rd_addr);
        end
        default: begin
          if (w_wr_accept) begin
            r_ack <= 1'b1;
            // Out-of-range writes are acknowledged but never reach the RAM.
            if (iWr_Addr < FB_LIMIT) begin
              r_we    <= 1'b1;
              r_addr  <= iWr_Addr;
              r_wdata <= iWr_Data;
            end
          end
        end
      endcase

      // Read pipeline: RAM data is valid the cycle after the address, and
      // each captured pixel is shown for two cycles (horizontal doubling).
      r_rd_p2 <= (r_state == S_ACT_RD);
      r_rd_p3 <= r_rd_p2;
      if (r_rd_p2) begin
        r_pix     <= iMem_RData;
        r_pix_vld <= 1'b1;
      end else if (r_rd_p3) begin
        r_pix_vld <= 1'b1;
      end else begin
        r_pix     <= '0;
        r_pix_vld <= 1'b0;
      end
    end
  end

  assign oMem_Addr    = r_addr;
  assign oMem_WE      = r_we;
  assign oMem_WData   = r_wdata;
  assign oWr_Ack      = r_ack;
  assign oPixel       = r_pix;
  assign oPixel_Valid = r_pix_vld;

`ifdef VGA_FB_ARB_WAIT_STATS_EN
  // Wait is counted in cycles a pending request was refused before acceptance.
  logic [15:0] r_wait_cur;
  logic [15:0] r_wait_max;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_wait_cur <= '0;
      r_wait_max <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wait_cur <= '0;
        if (r_wait_cur > r_wait_max) begin
          r_wait_max <= r_wait_cur;
        end
      end else if (w_wr_pend) begin
        if (r_wait_cur != 16'hFFFF) begin
          r_wait_cur <= r_wait_cur + 16'd1;
        end
      end else begin
        r_wait_cur <= '0;
      end
      if (iStats_Clr) begin
        r_wait_max <= '0;
      end
    end
  end

  assign oWait_Max = r_wait_max;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_fb_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [9:0]  iH_Cont;
  logic [9:0]  iV_Cont;
  logic        iWr_Req;
  logic [16:0] iWr_Addr;
  logic [7:0]  iWr_Data;
  logic        oWr_Ack;
  logic [16:0] oMem_Addr;
  logic        oMem_WE;
  logic [7:0]  oMem_WData;
  logic [7:0]  iMem_RData;
  logic [7:0]  oPixel;
  logic        oPixel_Valid;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [0:76799];

  always #5 iCLK = ~iCLK;

  vga_fb_arbiter dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iH_Cont      (iH_Cont),
    .iV_Cont      (iV_Cont),
    .iWr_Req      (iWr_Req),
    .iWr_Addr     (iWr_Addr),
    .iWr_Data     (iWr_Data),
    .oWr_Ack      (oWr_Ack),
    .oMem_Addr    (oMem_Addr),
    .oMem_WE      (oMem_WE),
    .oMem_WData   (oMem_WData),
    .iMem_RData   (iMem_RData),
    .oPixel       (oPixel),
    .oPixel_Valid (oPixel_Valid)
  );

  // Single-port RAM, read data one cycle after the address.
  always @(posedge iCLK) begin
    if (oMem_WE) mem[oMem_Addr] <= oMem_WData;
    iMem_RData <= mem[oMem_Addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present counters for one cycle; afterwards outputs belong to cycle h+1.
  task automatic cyc(input logic [9:0] h, input logic [9:0] v);
    iH_Cont = h;
    iV_Cont = v;
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    // Pattern 7*i+3; addr 0 overridden to 0xA5.
    // mem[1]=0x0A mem[320]=0xC3 mem[639]=0x7C mem[640]=0x83 mem[2642]=0x41
    for (int i = 0; i < 76800; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'hA5;

    iRST_N = 1'b0; iWr_Req = 1'b0; iWr_Addr = '0; iWr_Data = '0;
    iH_Cont = '0;  iV_Cont = '0;

    // Reset held, released for the cycle at H=137 on line 34.
    for (int h = 130; h < 137; h++) cyc(10'(h), 10'd34);
    chk("rst_addr",  oMem_Addr, 0);
    chk("rst_we",    oMem_WE, 0);
    chk("rst_ack",   oWr_Ack, 0);
    chk("rst_pixv",  oPixel_Valid, 0);
    iRST_N = 1'b1;
    for (int h = 137; h < 150; h++) begin
      cyc(10'(h), 10'd34);
      if (h == 137) begin chk("l34_addr0", oMem_Addr, 0); chk("l34_we0", oMem_WE, 0); end
      if (h == 138) chk("l34_pixv139", oPixel_Valid, 0);
      if (h == 139) begin chk("l34_pix140", oPixel, 8'hA5); chk("l34_pixv140", oPixel_Valid, 1); end
      if (h == 140) begin chk("l34_pix141", oPixel, 8'hA5); chk("l34_pixv141", oPixel_Valid, 1); end
      if (h == 141) chk("l34_pix142", oPixel, 8'h0A);
    end

    // Line 36 (row 1) full scan, line 37 re-reads row 1.
    for (int h = 130; h < 790; h++) begin
      cyc(10'(h), 10'd36);
      if (h == 137) chk("l36_addr", oMem_Addr, 320);
      if (h == 139) begin chk("l36_addr141", oMem_Addr, 321); chk("l36_pix140", oPixel, 8'hC3); end
      if (h == 775) chk("l36_last_addr", oMem_Addr, 639);
      if (h == 777) begin chk("l36_pix778", oPixel, 8'h7C); chk("l36_pixv778", oPixel_Valid, 1); end
      if (h == 778) begin chk("l36_pix779", oPixel, 8'h7C); chk("l36_pixv779", oPixel_Valid, 1); end
      if (h == 779) begin chk("l36_pix780", oPixel, 0); chk("l36_pixv780", oPixel_Valid, 0); end
    end
    for (int h = 130; h < 140; h++) begin
      cyc(10'(h), 10'd37);
      if (h == 137) chk("l37_addr", oMem_Addr, 320);
    end

    // Host request arriving in a read slot waits one cycle.
    for (int h = 130; h < 137; h++) cyc(10'(h), 10'd38);
    iWr_Req = 1'b1; iWr_Addr = 17'd1000; iWr_Data = 8'h3C;
    cyc(10'd137, 10'd38);
    chk("wr_rdslot_ack", oWr_Ack, 0);
    chk("wr_rdslot_addr", oMem_Addr, 640);
    cyc(10'd138, 10'd38);
    chk("wr_ack",   oWr_Ack, 1);
    chk("wr_we",    oMem_WE, 1);
    chk("wr_addr",  oMem_Addr, 1000);
    chk("wr_wdata", oMem_WData, 8'h3C);
    iWr_Req = 1'b0;
    cyc(10'd139, 10'd38);
    chk("wr_ack_drop", oWr_Ack, 0);
    chk("wr_we_drop",  oMem_WE, 0);
    chk("wr_rd_addr",  oMem_Addr, 641);
    chk("wr_pix140",   oPixel, 8'h83);
    chk("wr_mem1000",  mem[1000], 8'h3C);

    // Continuous request in vertical blanking: ack every 2nd cycle, no reads.
    cyc(10'd199, 10'd10);
    iWr_Req = 1'b1; iWr_Addr = 17'd2000; iWr_Data = 8'h11;
    for (int k = 0; k < 8; k++) begin
      cyc(10'(200 + k), 10'd10);
      chk("blk_ack",  oWr_Ack, 32'(k % 2 == 0));
      chk("blk_we",   oMem_WE, 32'(k % 2 == 0));
      chk("blk_addr", oMem_Addr, 2000);
    end
    iWr_Req = 1'b0;
    cyc(10'd208, 10'd10);

    // Out-of-range write is acknowledged and dropped.
    iWr_Req = 1'b1; iWr_Addr = 17'd76800; iWr_Data = 8'h77;
    cyc(10'd300, 10'd10);
    chk("oor_ack",  oWr_Ack, 1);
    chk("oor_we",   oMem_WE, 0);
    chk("oor_addr", oMem_Addr, 2000);
    iWr_Req = 1'b0;
    cyc(10'd301, 10'd10);
    chk("oor_ack_drop", oWr_Ack, 0);

    // Mid-line reset with a pending request.
    for (int h = 280; h < 299; h++) cyc(10'(h), 10'd50);
    iWr_Req = 1'b1; iWr_Addr = 17'd77; iWr_Data = 8'h99;
    cyc(10'd299, 10'd50);
    chk("mid_pixv_pre", oPixel_Valid, 1);
    iRST_N = 1'b0;
    cyc(10'd300, 10'd50);
    chk("mid_rst_addr",  oMem_Addr, 0);
    chk("mid_rst_we",    oMem_WE, 0);
    chk("mid_rst_wdata", oMem_WData, 0);
    chk("mid_rst_ack",   oWr_Ack, 0);
    chk("mid_rst_pix",   oPixel, 0);
    chk("mid_rst_pixv",  oPixel_Valid, 0);
    iRST_N = 1'b1;
    cyc(10'd301, 10'd50);
    chk("mid_ack302",  oWr_Ack, 0);
    chk("mid_addr302", oMem_Addr, 2642);
    cyc(10'd302, 10'd50);
    chk("mid_ack303",   oWr_Ack, 1);
    chk("mid_we303",    oMem_WE, 1);
    chk("mid_addr303",  oMem_Addr, 77);
    chk("mid_wdata303", oMem_WData, 8'h99);
    chk("mid_pixv303",  oPixel_Valid, 0);
    iWr_Req = 1'b0;
    cyc(10'd303, 10'd50);
    chk("mid_pix304",  oPixel, 8'h41);
    chk("mid_pixv304", oPixel_Valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM (320x240, 8-bit pixels) between the display fetch path and a host write port.
- Display reads are real-time and always win. The host gets every other cycle inside the active region and every cycle during blanking.
- The block scans the 320x240 buffer out 2x-scaled (each pixel doubled horizontally and vertically) for the 640x480 VGA timing.
- It is driven by the H_Cont/V_Cont counters from the VGA timing controller. It feeds that controller's colour inputs through a palette/expansion stage.

Parameters:
- H_ACT_START, 140, value of iH_Cont at the first visible pixel; must be >= 3.
- V_ACT_START, 34, value of iV_Cont at the first visible line.
- H_ACT, 640, visible pixels per line.
- V_ACT, 480, visible lines.
- FB_W, 320, framebuffer width (H_ACT/2).
- FB_H, 240, framebuffer height (V_ACT/2).
- ADDR_W, 17, framebuffer address width.
- DATA_W, 8, pixel width.

Ports:
- iCLK  in  1  pixel clock, shared with the VGA timing controller.
- iRST_N  in  1  reset, synchronous, active-low.
- iH_Cont  in  10  horizontal counter from the timing controller.
- iV_Cont  in  10  vertical counter from the timing controller.
- iWr_Req  in  1  host write request (level).
- iWr_Addr  in  ADDR_W  host write address, linear (row*FB_W + col).
- iWr_Data  in  DATA_W  host write data.
- oWr_Ack  out  1  one-cycle pulse: write accepted.
- oMem_Addr  out  ADDR_W  RAM address (registered).
- oMem_WE  out  1  RAM write enable (registered).
- oMem_WData  out  DATA_W  RAM write data (registered).
- iMem_RData  in  DATA_W  RAM read data; read latency is 1 cycle after oMem_Addr.
- oPixel  out  DATA_W  pixel for the current iH_Cont/iV_Cont position.
- oPixel_Valid  out  1  high when the current position is visible.

Behaviour:
- Reset: clock is iCLK; reset is synchronous, active-low on iRST_N.
  - All outputs are 0 on the edge after iRST_N is sampled low.
  - FSM goes to S_BLANK. No pending request is acked.
  - A request held through reset is serviced normally afterwards.
- Definitions:
  - y = iV_Cont - V_ACT_START. A line is active when 0 <= y < V_ACT.
  - s = iH_Cont - (H_ACT_START-3). A read slot is any cycle on an active line with s even and 0 <= s <= 2*FB_W-2; its column is c = s/2.
  - Every other cycle is a write slot.
- FSM states, re-evaluated every cycle from the counters:
  - S_BLANK: not an active line, or s outside the read window.
  - S_ACT_RD: read slot.
  - S_ACT_WR: odd s inside the window.
  - Per-cycle actions are the same in S_BLANK and S_ACT_WR. The state is exported only for debug and coverage.
- Read slot, with the decision at cycle t:
  - t+1: oMem_Addr = (y>>1)*FB_W + c and oMem_WE = 0. The multiply is implemented as (r<<8)+(r<<6), 17-bit, no multiplier.
  - t+2: iMem_RData is captured.
  - t+3: oPixel holds the value, with oPixel_Valid = 1 for 2 cycles. So display x appears on oPixel in the cycle where iH_Cont == H_ACT_START + x.
- Each buffer row is fetched on both lines 2r and 2r+1.
- Outside the visible region: oPixel = 0 and oPixel_Valid = 0.
- Write slot with iWr_Req = 1 and no oWr_Ack in the previous cycle:
  - Next cycle: oMem_WE = 1, oMem_Addr = iWr_Addr, oMem_WData = iWr_Data, oWr_Ack = 1. All four are coincident.
  - The host drops the request or presents new address/data in the cycle after the ack.
  - A back-to-back request is therefore accepted at most every 2 cycles.
- Request arriving in a read slot: waits. Worst-case wait is 1 cycle in the active region and 0 cycles in blanking.
- Out-of-range write (iWr_Addr >= FB_W*FB_H): acked but oMem_WE stays 0 (dropped).
- When no read or write is issued: oMem_WE = 0 and oMem_Addr holds its previous value.
- Counter wrap (iH_Cont returning to 0): no special handling. Slot classification is purely combinational on the counters.

Optional Feature:
- Macro VGA_FB_ARB_WAIT_STATS_EN.
- Defined: adds output oWait_Max[15:0], the longest request-to-ack wait in cycles.
  - It saturates at 0xFFFF.
  - It is cleared by reset or by the additional input iStats_Clr (1 bit, clear on the next edge).
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_ACT_START, V_ACT_START, H_ACT, V_ACT);
  - FB_W, FB_H and FB_SIZE = 76800;
  - typedef fb_addr_t (logic [16:0]) and pixel_t (logic [7:0]);
  - enum arb_state_t {S_BLANK, S_ACT_RD, S_ACT_WR}.
- One sub-module: vga_fb_addr_gen. It maps the counters to the slot type and the read address (row base by shift-add, plus column).

Test Plan:
- Reset held, then released at iV_Cont=34, iH_Cont=137 -> oMem_Addr=0 with oMem_WE=0 at H=138. Then RAM data 0xA5 -> oPixel=0xA5, oPixel_Valid=1 at H=140 and H=141.
- iV_Cont=36, iH_Cont=137 -> oMem_Addr=320. At iV_Cont=37 the same address is re-read. At H=775 -> oMem_Addr=639 at H=776, with the last pixel on H=778..779.
- iWr_Req held with Addr=1000, Data=0x3C, presented at H=137 (read slot) -> no ack at H=138. Ack, WE=1, Addr=1000, WData=0x3C at H=139.
- iWr_Req held continuously in vertical blanking (iV_Cont=10) -> oWr_Ack pulses every 2nd cycle, and no read is ever issued.
- iWr_Addr=76800 -> oWr_Ack=1 while oMem_WE stays 0.
- iRST_N low mid-line at H=300 with a request pending -> all outputs 0 on the next edge. After release, the request is acked in the first write slot.
